// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//
// Iterative multiply/divide unit for MIPS32 MULT, MULTU, DIV, DIVU, MTHI and
// MTLO. It owns the architectural HI/LO registers. Multiplies and divides take
// WIDTH iteration edges plus one sign-fix edge. MTHI/MTLO write in a single
// edge without raising busy.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   start    in   operation request, sampled on the clk edge
//   md_op    in   3'b000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                 100 MTHI, 101 MTLO, 110/111 no-op
//   a        in   rs operand (multiplicand / dividend / MT source)
//   b        in   rt operand (multiplier / divisor)
//   hi, lo   out  HI / LO registers
//   busy     out  iteration in progress; start is ignored while high
//   done     out  one-cycle pulse after HI/LO were updated
//   div_zero out  (only with MULDIV_DIV0_FLAG_EN) sticky divide-by-zero flag
//
// Optional feature macro: MULDIV_DIV0_FLAG_EN
//
// Handshake: a request is accepted on a rising edge where start=1 and the
// unit is idle (busy=0). A request while busy=1 is dropped, not queued. done
// is high for exactly one cycle after the edge that wrote HI/LO.
// -----------------------------------------------------------------------------
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
`ifdef MULDIV_DIV0_FLAG_EN
    ,
    output logic             div_zero
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    // Shared working register:
    //   multiply: {partial product high half, remaining multiplier bits}
    //   divide:   {partial remainder, dividend bits shifting into quotient}
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;   // |multiplicand| or |divisor|
    logic              is_div_q, is_div_d;
    logic              sa_q, sa_d;
    logic              neg_q, neg_d;     // sa ^ sb
    logic              bzero_q, bzero_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              done_q, done_d;
`ifdef MULDIV_DIV0_FLAG_EN
    logic              div_zero_q, div_zero_d;
`endif

    // Operand conditioning for the accepting edge
    logic              op_signed;
    logic              sgn_a, sgn_b;
    logic [WIDTH-1:0]  abs_a, abs_b;

    // Iteration datapath
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift;
    logic [WIDTH+1:0]  div_diff;
    logic [2*WIDTH-1:0] prod_neg;

    always_comb begin
        op_signed = ~md_op[0];
        sgn_a     = op_signed & a[WIDTH-1];
        sgn_b     = op_signed & b[WIDTH-1];
        abs_a     = sgn_a ? -a : a;
        abs_b     = sgn_b ? -b : b;
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            p_q        <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            sa_q       <= 1'b0;
            neg_q      <= 1'b0;
            bzero_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            p_q        <= p_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            sa_q       <= sa_d;
            neg_q      <= neg_d;
            bzero_q    <= bzero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
`ifdef MULDIV_DIV0_FLAG_EN
            div_zero_q <= div_zero_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        p_d        = p_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        sa_d       = sa_q;
        neg_d      = neg_q;
        bzero_d    = bzero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
        div_zero_d = div_zero_q;
`endif

        // Shift-add step: add multiplicand to the high half when the current
        // multiplier LSB is set, then shift the whole register right.
        mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? opnd_q : '0)};
        // Restoring step: shift the next dividend bit into the remainder and
        // try subtracting the divisor. One extra bit keeps the borrow exact
        // even when the shifted remainder uses its top bit (divisor of zero).
        div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
        prod_neg  = -p_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            is_div_d = md_op[1];
                            sa_d     = sgn_a;
                            neg_d    = sgn_a ^ sgn_b;
                            bzero_d  = (b == '0);
                            count_d  = '0;
                            state_d  = CALC;
                            if (md_op[1]) begin
                                p_d    = {{WIDTH{1'b0}}, abs_a};
                                opnd_d = abs_b;
                            end else begin
                                p_d    = {{WIDTH{1'b0}}, abs_b};
                                opnd_d = abs_a;
                            end
                        end
                        3'b100: begin
                            hi_d   = a;
                            done_d = 1'b1;
                        end
                        3'b101: begin
                            lo_d   = a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            CALC: begin
                if (is_div_q) begin
                    if (!div_diff[WIDTH+1]) begin
                        p_d = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
                    end else begin
                        p_d = {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    p_d = {mul_sum, p_q[WIDTH-1:1]};
                end
                count_d = count_q + CW'(1);
                if (count_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (is_div_q) begin
                    // Remainder takes the dividend's sign (truncating division).
                    // With a zero divisor the remainder equals |a|, so the same
                    // fix restores the original a; the quotient is forced.
                    hi_d = sa_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
                    if (bzero_q) begin
                        lo_d = '1;
                    end else begin
                        lo_d = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
                    end
`ifdef MULDIV_DIV0_FLAG_EN
                    div_zero_d = bzero_q;
`endif
                end else begin
                    hi_d = neg_q ? prod_neg[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
                    lo_d = neg_q ? prod_neg[WIDTH-1:0]       : p_q[WIDTH-1:0];
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy = (state_q != IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
`ifdef MULDIV_DIV0_FLAG_EN
        div_zero = div_zero_q;
`endif
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//
// Directed self-checking bench for mul_div_unit. Inputs are driven and outputs
// sampled 1 time unit after each rising edge. Every expected value is a
// hand-computed constant.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
`ifdef MULDIV_DIV0_FLAG_EN
    logic        div_zero;
`endif

    int n_cmp;
    int n_err;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
`ifdef MULDIV_DIV0_FLAG_EN
        ,
        .div_zero (div_zero)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request for exactly one edge, then scramble a/b to show the
    // operands were captured at the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1;
        md_op = op;
        a     = va;
        b     = vb;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Called just after the accepting edge. Returns the cycle index (1 = the
    // cycle right after the accepting edge) in which done is seen.
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(op, va, vb);
        wait_done(n);
        check({tag, " latency"}, n, 34);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int done_seen;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        md_op = 3'b000;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", {31'b0, busy}, 32'h0);
        check("reset done", {31'b0, done}, 32'h0);
        rst_n = 1'b1;
        tick();

        // MULT -2 * 3, with mid-operation checks
        issue(3'b000, 32'hFFFF_FFFE, 32'h0000_0003);
        check("mult busy after accept", {31'b0, busy}, 32'h1);
        check("mult hi held", hi, 32'h0);
        wait_done(n);
        check("mult latency", n, 34);
        check("mult hi", hi, 32'hFFFF_FFFF);
        check("mult lo", lo, 32'hFFFF_FFFA);
        check("mult busy at done", {31'b0, busy}, 32'h0);
        tick();
        check("mult done one cycle", {31'b0, done}, 32'h0);

        run_op("multu", 3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA);
        tick();

        // Reset during a running DIV
        issue(3'b010, 32'h0000_0064, 32'h0000_0007);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        tick();
        check("midreset hi", hi, 32'h0);
        check("midreset lo", lo, 32'h0);
        check("midreset busy", {31'b0, busy}, 32'h0);
        check("midreset done", {31'b0, done}, 32'h0);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_seen++;
        end
        check("midreset no done after", done_seen, 0);
        check("midreset lo stays", lo, 32'h0);

        // Divides
        run_op("div -7/2", 3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        tick();
        run_op("divu 100/7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);
        tick();
        run_op("div minint/-1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        tick();
        run_op("div 7/-2", 3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        tick();

        // Divide by zero
        run_op("divu /0", 3'b011, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF);
`ifdef MULDIV_DIV0_FLAG_EN
        check("div_zero set", {31'b0, div_zero}, 32'h1);
`endif
        tick();
        run_op("div neg/0", 3'b010, 32'hFFFF_FF00, 32'h0, 32'hFFFF_FF00, 32'hFFFF_FFFF);
        tick();
        run_op("mult after div0", 3'b000, 32'h0000_0004, 32'h0000_0005, 32'h0, 32'd20);
`ifdef MULDIV_DIV0_FLAG_EN
        check("div_zero sticky over mult", {31'b0, div_zero}, 32'h1);
`endif
        tick();
        run_op("divu 10/3", 3'b011, 32'd10, 32'd3, 32'd1, 32'd3);
`ifdef MULDIV_DIV0_FLAG_EN
        check("div_zero cleared", {31'b0, div_zero}, 32'h0);
`endif
        tick();

        // MTHI in idle
        issue(3'b100, 32'hDEAD_BEEF, 32'h0);
        check("mthi hi", hi, 32'hDEAD_BEEF);
        check("mthi lo unchanged", lo, 32'd3);
        check("mthi done", {31'b0, done}, 32'h1);
        check("mthi busy", {31'b0, busy}, 32'h0);
        tick();
        check("mthi done one cycle", {31'b0, done}, 32'h0);

        // MTLO in idle
        issue(3'b101, 32'h0BAD_F00D, 32'h0);
        check("mtlo lo", lo, 32'h0BAD_F00D);
        check("mtlo hi unchanged", hi, 32'hDEAD_BEEF);
        tick();

        // No-op codes produce nothing
        issue(3'b110, 32'h1111_1111, 32'h2222_2222);
        check("nop done", {31'b0, done}, 32'h0);
        check("nop busy", {31'b0, busy}, 32'h0);
        issue(3'b111, 32'h3333_3333, 32'h4444_4444);
        check("nop hi", hi, 32'hDEAD_BEEF);
        check("nop lo", lo, 32'h0BAD_F00D);

        // MTLO while a MULT is busy is dropped
        issue(3'b000, 32'd7, 32'd9);
        repeat (4) tick();
        issue(3'b101, 32'h0000_0055, 32'h0);
        check("mtlo busy no done", {31'b0, done}, 32'h0);
        check("mtlo busy lo held", lo, 32'h0BAD_F00D);
        wait_done(n);
        check("mtlo busy latency", n, 29);
        check("mtlo busy hi", hi, 32'h0);
        check("mtlo busy lo", lo, 32'd63);
        tick();

        // Back-to-back MULTU 5*6 with start held high
        start = 1'b1;
        md_op = 3'b001;
        a     = 32'd5;
        b     = 32'd6;
        tick();
        wait_done(n);
        check("b2b first latency", n, 34);
        check("b2b first lo", lo, 32'd30);
        tick();
        check("b2b second accepted", {31'b0, busy}, 32'h1);
        wait_done(n);
        start = 1'b0;
        check("b2b second latency", n, 34);
        check("b2b hi", hi, 32'h0);
        check("b2b lo", lo, 32'd30);
        tick();
        check("b2b idle after", {31'b0, busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
